// File: rtl/ps2_key_event_decoder.sv
// PS/2 scan-code set 2 decoder: make/break/E0/E1-Pause sequences to a FWFT event FIFO.
// Optional auto-repeat suppression is built when PS2_TYPEMATIC_FILTER_EN is defined.
module ps2_key_event_decoder #(
    parameter int unsigned FIFO_AW    = 2,
    parameter logic [7:0]  PAUSE_CODE = 8'h77
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               rx_done_i,
    input  logic [7:0]         rx_data_i,
    input  logic               ev_rd_i,
    output logic               ev_valid_o,
    output logic [7:0]         ev_code_o,
    output logic               ev_ext_o,
    output logic               ev_brk_o,
    output logic [FIFO_AW:0]   ev_count_o,
    output logic [7:0]         last_break_o,
    output logic               ovf_o,
    output logic               seq_err_o
);

    localparam int unsigned          Depth     = 2 ** FIFO_AW;
    localparam logic [FIFO_AW-1:0]   PtrOne    = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]     CntOne    = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]     FullCount = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [2:0]           PauseSkip = 3'd7;

    typedef enum logic [1:0] {StIdle, StE0, StF0, StPause} state_e;

    state_e      state_q, state_d;
    logic        ext_q, ext_d;
    logic [2:0]  skip_q, skip_d;

    logic        is_e0, is_f0, is_e1, is_prefix, is_nonkey;

    logic        dec_push;
    logic [7:0]  dec_code;
    logic        dec_ext;
    logic        dec_brk;
    logic        seq_err_set;
    logic        ev_push;

    logic [9:0]         mem_q [Depth];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q, head_idx;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               fifo_full, pop, wr_en;
    logic [7:0]         last_break_q;
    logic               ovf_q, seq_err_q;

    assign is_e0     = (rx_data_i == 8'hE0);
    assign is_f0     = (rx_data_i == 8'hF0);
    assign is_e1     = (rx_data_i == 8'hE1);
    assign is_prefix = is_e0 | is_f0 | is_e1;
    assign is_nonkey = (rx_data_i == 8'hAA) | (rx_data_i == 8'hFA) | (rx_data_i == 8'hFE) |
                       (rx_data_i == 8'hEE) | (rx_data_i == 8'h00) | (rx_data_i == 8'hFF);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            ext_q   <= 1'b0;
            skip_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            ext_q   <= ext_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ext_d   = ext_q;
        skip_d  = skip_q;
        if (rx_done_i) begin
            unique case (state_q)
                StIdle: begin
                    if (is_e0) begin
                        ext_d   = 1'b1;
                        state_d = StE0;
                    end else if (is_f0) begin
                        ext_d   = 1'b0;
                        state_d = StF0;
                    end else if (is_e1) begin
                        skip_d  = PauseSkip;
                        state_d = StPause;
                    end
                end
                StE0: begin
                    if (is_f0) begin
                        state_d = StF0;
                    end else if (is_e1) begin
                        skip_d  = PauseSkip;
                        state_d = StPause;
                    end else if (!is_e0) begin
                        ext_d   = 1'b0;
                        state_d = StIdle;
                    end
                end
                StF0: begin
                    ext_d = 1'b0;
                    if (is_e1) begin
                        skip_d  = PauseSkip;
                        state_d = StPause;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StPause: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        ext_d   = 1'b0;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Decoded event for this byte, before any filtering or FIFO admission.
    always_comb begin
        dec_push    = 1'b0;
        dec_code    = rx_data_i;
        dec_ext     = 1'b0;
        dec_brk     = 1'b0;
        seq_err_set = 1'b0;
        if (rx_done_i) begin
            unique case (state_q)
                StIdle: begin
                    dec_push = !is_prefix && !is_nonkey;
                end
                StE0: begin
                    dec_push = !is_prefix;
                    dec_ext  = 1'b1;
                end
                StF0: begin
                    seq_err_set = is_prefix;
                    dec_push    = !is_prefix;
                    dec_ext     = ext_q;
                    dec_brk     = 1'b1;
                end
                StPause: begin
                    dec_push = (skip_q == 3'd1);
                    dec_code = PAUSE_CODE;
                    dec_ext  = 1'b1;
                end
                default: dec_push = 1'b0;
            endcase
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       held_v_q, held_ext_q;
    logic [7:0] held_code_q;
    logic       dec_pause, held_match, is_make;

    assign dec_pause  = (state_q == StPause);
    assign is_make    = dec_push && !dec_brk && !dec_pause;
    assign held_match = held_v_q && (held_ext_q == dec_ext) && (held_code_q == dec_code);
    // Repeated makes of the held key are auto-repeat and never reach the FIFO.
    assign ev_push    = dec_push && !(is_make && held_match);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            held_v_q    <= 1'b0;
            held_ext_q  <= 1'b0;
            held_code_q <= 8'h00;
        end else if (is_make && !held_match) begin
            held_v_q    <= 1'b1;
            held_ext_q  <= dec_ext;
            held_code_q <= dec_code;
        end else if (dec_push && dec_brk && held_match) begin
            held_v_q    <= 1'b0;
        end
    end
`else
    assign ev_push = dec_push;
`endif

    assign fifo_full = (count_q == FullCount);
    assign pop       = ev_rd_i && (count_q != '0);
    assign wr_en     = ev_push && (!fifo_full || pop);

    always_comb begin
        count_d = count_q;
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_break_q <= 8'h00;
            ovf_q        <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= {dec_ext, dec_brk, dec_code};
                wr_ptr_q        <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            count_q <= count_d;
            if (dec_push && dec_brk) begin
                last_break_q <= dec_code;
            end
            if (ev_push && fifo_full && !pop) begin
                ovf_q <= 1'b1;
            end
            if (seq_err_set) begin
                seq_err_q <= 1'b1;
            end
        end
    end

    // When empty, the slot just behind the read pointer still holds the last popped event.
    assign head_idx = (count_q == '0) ? (rd_ptr_q - PtrOne) : rd_ptr_q;

    assign {ev_ext_o, ev_brk_o, ev_code_o} = mem_q[head_idx];
    assign ev_valid_o   = (count_q != '0);
    assign ev_count_o   = count_q;
    assign last_break_o = last_break_q;
    assign ovf_o        = ovf_q;
    assign seq_err_o    = seq_err_q;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Bench for ps2_key_event_decoder: directed scenarios plus random bytes against a
// sequence-level model; honours PS2_TYPEMATIC_FILTER_EN like the design.
module tb_ps2_key_event_decoder;

    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic        ev_rd;
    logic        ev_valid;
    logic [7:0]  ev_code;
    logic        ev_ext;
    logic        ev_brk;
    logic [AW:0] ev_count;
    logic [7:0]  last_break;
    logic        ovf;
    logic        seq_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ps2_key_event_decoder #(
        .FIFO_AW    (AW),
        .PAUSE_CODE (8'h77)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .rx_done_i    (rx_done),
        .rx_data_i    (rx_data),
        .ev_rd_i      (ev_rd),
        .ev_valid_o   (ev_valid),
        .ev_code_o    (ev_code),
        .ev_ext_o     (ev_ext),
        .ev_brk_o     (ev_brk),
        .ev_count_o   (ev_count),
        .last_break_o (last_break),
        .ovf_o        (ovf),
        .seq_err_o    (seq_err)
    );

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ev_t;

    // Reference model: pending prefix bytes, pause countdown, event queue.
    ev_t        mq[$];
    ev_t        m_shown;
    logic [7:0] m_last_break;
    logic       m_ovf, m_seq_err;
    logic [7:0] pfx[$];
    int         pause_left;
    logic       h_v, h_ext;
    logic [7:0] h_code;

    function automatic void m_reset();
        mq.delete();
        pfx.delete();
        m_shown      = '0;
        m_last_break = 8'h00;
        m_ovf        = 1'b0;
        m_seq_err    = 1'b0;
        pause_left   = 0;
        h_v          = 1'b0;
        h_ext        = 1'b0;
        h_code       = 8'h00;
    endfunction

    function automatic void m_emit(logic [7:0] code, logic ext, logic brk, logic pause);
        ev_t e;
        logic match;
        if (brk) m_last_break = code;
        match = h_v && (h_ext == ext) && (h_code == code);
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (!pause) begin
            if (!brk) begin
                if (match) return;
                h_v = 1'b1; h_ext = ext; h_code = code;
            end else if (match) begin
                h_v = 1'b0;
            end
        end
`endif
        e.ext = ext; e.brk = brk; e.code = code;
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_ovf = 1'b1;
    endfunction

    function automatic void m_byte(logic [7:0] b);
        logic f0_pending;
        logic ext;
        if (pause_left > 0) begin
            pause_left--;
            if (pause_left == 0) m_emit(8'h77, 1'b1, 1'b0, 1'b1);
            return;
        end
        f0_pending = (pfx.size() > 0) && (pfx[pfx.size()-1] == 8'hF0);
        if (b == 8'hE1) begin
            if (f0_pending) m_seq_err = 1'b1;
            pfx.delete();
            pause_left = 7;
            return;
        end
        if (b == 8'hE0 || b == 8'hF0) begin
            if (f0_pending) begin
                m_seq_err = 1'b1;
                pfx.delete();
            end else if (b == 8'hF0) begin
                pfx.push_back(b);
            end else if (pfx.size() == 0) begin
                pfx.push_back(b);
            end
            return;
        end
        if (pfx.size() == 0 && (b == 8'hAA || b == 8'hFA || b == 8'hFE ||
                                b == 8'hEE || b == 8'h00 || b == 8'hFF)) return;
        ext = (pfx.size() > 0) && (pfx[0] == 8'hE0);
        m_emit(b, ext, f0_pending, 1'b0);
        pfx.delete();
    endfunction

    // One clock of stimulus; model advances alongside, outputs sampled #1 after the edge.
    task automatic step(input logic rst, input logic dv, input logic [7:0] b, input logic rd);
        reset   = rst;
        rx_done = dv;
        rx_data = b;
        ev_rd   = rd;
        @(posedge clk);
        #1;
        if (rst) begin
            m_reset();
        end else begin
            if (rd && mq.size() > 0) mq.delete(0);
            if (dv) m_byte(b);
        end
        if (mq.size() > 0) m_shown = mq[0];
        reset   = 1'b0;
        rx_done = 1'b0;
        ev_rd   = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b0, 1'b1, b, 1'b0);
    endtask

    task automatic test_reset();
        send(8'h1C); send(8'hF0); send(8'hE1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        checks += 4;
        if (ev_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", ev_valid); end
        if (ev_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", ev_count); end
        if ({ev_ext, ev_brk, ev_code} !== 10'h000)
            begin failures++; $display("FAIL reset_head: got %h want 000", {ev_ext, ev_brk, ev_code}); end
        if ({last_break, ovf, seq_err} !== 10'h000)
            begin failures++; $display("FAIL reset_flags: got %h want 000", {last_break, ovf, seq_err}); end
    endtask

    task automatic test_make_break();
        step(1'b1, 1'b0, 8'h00, 1'b0);
        send(8'h1C);
        checks++;
        if (ev_valid !== 1'b1) begin failures++; $display("FAIL mb_latency: got %b want 1", ev_valid); end
        send(8'hF0); send(8'h1C);
        checks += 3;
        if (ev_count !== 3'd2) begin failures++; $display("FAIL mb_count: got %0d want 2", ev_count); end
        if ({ev_ext, ev_brk, ev_code} !== 10'h01C)
            begin failures++; $display("FAIL mb_head0: got %h want 01c", {ev_ext, ev_brk, ev_code}); end
        if (last_break !== 8'h1C) begin failures++; $display("FAIL mb_last_break: got %h want 1c", last_break); end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if ({ev_ext, ev_brk, ev_code} !== 10'h11C)
            begin failures++; $display("FAIL mb_head1: got %h want 11c", {ev_ext, ev_brk, ev_code}); end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        checks += 2;
        if (ev_valid !== 1'b0) begin failures++; $display("FAIL mb_empty: got %b want 0", ev_valid); end
        if ({ev_ext, ev_brk, ev_code} !== 10'h11C)
            begin failures++; $display("FAIL mb_hold: got %h want 11c", {ev_ext, ev_brk, ev_code}); end
    endtask

    task automatic test_extended();
        step(1'b1, 1'b0, 8'h00, 1'b0);
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        checks += 4;
        if (ev_count !== 3'd2) begin failures++; $display("FAIL ext_count: got %0d want 2", ev_count); end
        if ({ev_ext, ev_brk, ev_code} !== 10'h275)
            begin failures++; $display("FAIL ext_head0: got %h want 275", {ev_ext, ev_brk, ev_code}); end
        if (seq_err !== 1'b0) begin failures++; $display("FAIL ext_seq_err: got %b want 0", seq_err); end
        if (last_break !== 8'h75) begin failures++; $display("FAIL ext_last_break: got %h want 75", last_break); end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if ({ev_ext, ev_brk, ev_code} !== 10'h375)
            begin failures++; $display("FAIL ext_head1: got %h want 375", {ev_ext, ev_brk, ev_code}); end
    endtask

    task automatic test_pause();
        logic [7:0] seq [8];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) send(seq[i]);
        checks += 3;
        if (ev_count !== 3'd1) begin failures++; $display("FAIL pause_count: got %0d want 1", ev_count); end
        if ({ev_ext, ev_brk, ev_code} !== 10'h277)
            begin failures++; $display("FAIL pause_head: got %h want 277", {ev_ext, ev_brk, ev_code}); end
        if ({last_break, seq_err} !== 9'h000)
            begin failures++; $display("FAIL pause_flags: got %h want 000", {last_break, seq_err}); end
        send(8'h1C);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if ({ev_count, ev_ext, ev_brk, ev_code} !== {3'd1, 10'h01C})
            begin failures++; $display("FAIL pause_after: got %h want 41c", {ev_count, ev_ext, ev_brk, ev_code}); end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5];
        codes = '{8'h15, 8'h16, 8'h1A, 8'h1B, 8'h1C};
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) send(codes[i]);
        checks += 3;
        if (ev_count !== 3'd4) begin failures++; $display("FAIL ovf_count: got %0d want 4", ev_count); end
        if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b want 1", ovf); end
        if (ev_code !== 8'h15) begin failures++; $display("FAIL ovf_head: got %h want 15", ev_code); end
        step(1'b0, 1'b1, 8'h1D, 1'b1);
        checks += 2;
        if (ev_count !== 3'd4) begin failures++; $display("FAIL ovf_pushpop_count: got %0d want 4", ev_count); end
        if (ev_code !== 8'h16) begin failures++; $display("FAIL ovf_pushpop_head: got %h want 16", ev_code); end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (ev_code !== 8'h1D) begin failures++; $display("FAIL ovf_tail: got %h want 1d", ev_code); end
    endtask

    task automatic test_seq_err();
        step(1'b1, 1'b0, 8'h00, 1'b0);
        send(8'hF0); send(8'hE0); send(8'h1C);
        checks += 3;
        if (seq_err !== 1'b1) begin failures++; $display("FAIL serr_flag: got %b want 1", seq_err); end
        if ({ev_count, ev_ext, ev_brk, ev_code} !== {3'd1, 10'h01C})
            begin failures++; $display("FAIL serr_event: got %h want 41c", {ev_count, ev_ext, ev_brk, ev_code}); end
        if (last_break !== 8'h00) begin failures++; $display("FAIL serr_last_break: got %h want 00", last_break); end
        step(1'b1, 1'b0, 8'h00, 1'b0);
        send(8'hF0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        send(8'h1C);
        checks += 2;
        if ({ev_count, ev_ext, ev_brk, ev_code} !== {3'd1, 10'h01C})
            begin failures++; $display("FAIL rst_mid_event: got %h want 41c", {ev_count, ev_ext, ev_brk, ev_code}); end
        if ({last_break, seq_err} !== 9'h000)
            begin failures++; $display("FAIL rst_mid_flags: got %h want 000", {last_break, seq_err}); end
    endtask

    task automatic test_typematic();
        logic [7:0] seq [6];
        ev_t got[$];
        ev_t want[$];
        int  guard;
        seq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
`ifdef PS2_TYPEMATIC_FILTER_EN
        want = '{10'h01C, 10'h11C, 10'h01C};
`else
        want = '{10'h01C, 10'h01C, 10'h01C, 10'h11C, 10'h01C};
`endif
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) begin
            send(seq[i]);
            guard = 0;
            while (ev_valid === 1'b1 && guard < 8) begin
                got.push_back({ev_ext, ev_brk, ev_code});
                step(1'b0, 1'b0, 8'h00, 1'b1);
                guard++;
            end
        end
        checks++;
        if (got.size() != want.size())
            begin failures++; $display("FAIL typ_count: got %0d want %0d", got.size(), want.size()); end
        for (int i = 0; i < want.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== want[i])
                begin failures++; $display("FAIL typ_event%0d: got %h want %h", i, got[i], want[i]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] nk [6];
        logic [7:0] b;
        int r;
        nk = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 15);
            case (r)
                0, 1:    b = 8'hE0;
                2, 3:    b = 8'hF0;
                4:       b = 8'hE1;
                5:       b = nk[$urandom_range(0, 5)];
                6, 7, 8: b = 8'h1C;
                default: b = 8'($urandom);
            endcase
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 1) == 1), b,
                 ($urandom_range(0, 9) < 4));
            checks++;
            if ({ev_valid, ev_count} !== {(mq.size() > 0), 3'(mq.size())})
                begin failures++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, ev_count, mq.size()); end
            checks++;
            if ({ev_ext, ev_brk, ev_code} !== m_shown)
                begin failures++; $display("FAIL rnd_head@%0d: got %h want %h", n, {ev_ext, ev_brk, ev_code}, m_shown); end
            checks++;
            if ({last_break, ovf, seq_err} !== {m_last_break, m_ovf, m_seq_err})
                begin failures++; $display("FAIL rnd_flags@%0d: got %h want %h", n,
                    {last_break, ovf, seq_err}, {m_last_break, m_ovf, m_seq_err}); end
        end
    endtask

    initial begin
        reset   = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        ev_rd   = 1'b0;
        m_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0);
        test_reset();
        test_make_break();
        test_extended();
        test_pause();
        test_overflow();
        test_seq_err();
        test_typematic();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
